// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline encodings: PC mux select codes and hazard FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

    // PC mux select
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Hazard controller states
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect_unit.sv
// Purely combinational load-use and branch/jump-taken detection.
// Latency: 0 cycles (combinational).
// Backpressure: none; results are consumed by the hazard controller.
//
// Ports:
//   id_rs, id_rt, id_uses_rt        - source operands of the ID instruction
//   ex_mem_read, ex_write_register  - load in EX and its destination
//   mem_branch_eq/ne, mem_zero, mem_jump - resolved control flow in MEM
//   load_use, taken                 - detection outputs
module hazard_detect_unit (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_register,
    input  logic       mem_branch_eq,
    input  logic       mem_branch_ne,
    input  logic       mem_zero,
    input  logic       mem_jump,
    output logic       load_use,
    output logic       taken
);

    logic rs_match;
    logic rt_match;

    // $0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign rs_match = (ex_write_register == id_rs);
    assign rt_match = id_uses_rt && (ex_write_register == id_rt);
    assign load_use = ex_mem_read && (ex_write_register != 5'd0) && (rs_match || rt_match);

    assign taken = (mem_branch_eq && mem_zero) || (mem_branch_ne && !mem_zero) || mem_jump;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: write enables, flushes and PC select.
// Latency: strobes are Mealy (same cycle); state and counter update on falling clk.
// Backpressure: a busy data memory freezes every pipeline register and the PC.
//
// Ports:
//   clk, reset (async, active-low)
//   id_*, ex_*, mem_*  - stage fields read from the datapath
//   dmem_ready         - data memory completed the current access
//   *_write, *_flush   - pipeline register load enables / bubble strobes
//   pc_src             - PC mux select (seq / branch / jump)
//   dmem_req           - a data memory access is pending
//   stall_count        - saturating count of frozen or load-use stalled cycles
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_write_register,
    input  logic                   mem_branch_eq,
    input  logic                   mem_branch_ne,
    input  logic                   mem_zero,
    input  logic                   mem_jump,
    input  logic                   mem_mem_read,
    input  logic                   mem_mem_write,
    input  logic                   dmem_ready,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_write,
    output logic                   ex_mem_write,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic [1:0]             pc_src,
    output logic                   dmem_req,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_e                   state_q;
    state_e                   state_d;
    logic [STALL_CNT_W-1:0]   stall_count_q;
    logic [STALL_CNT_W-1:0]   stall_count_d;

    logic load_use;
    logic taken;
    logic mem_op;
    logic freeze;
    logic stall_inc;

    hazard_detect_unit u_hazard_detect_unit (
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_uses_rt        (id_uses_rt),
        .ex_mem_read       (ex_mem_read),
        .ex_write_register (ex_write_register),
        .mem_branch_eq     (mem_branch_eq),
        .mem_branch_ne     (mem_branch_ne),
        .mem_zero          (mem_zero),
        .mem_jump          (mem_jump),
        .load_use          (load_use),
        .taken             (taken)
    );

    assign mem_op = mem_mem_read || mem_mem_write;
    // Freeze is evaluated identically in RUN and MEM_WAIT, so a zero-wait
    // access never enters MEM_WAIT and costs nothing.
    assign freeze = mem_op && !dmem_ready;

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (freeze)  state_d = MEM_WAIT;
            MEM_WAIT: if (!freeze) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Mealy strobes, priority: freeze > redirect > load-use > normal
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_src       = PC_SRC_SEQ;
        dmem_req     = mem_op;
        stall_inc    = 1'b0;

        if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            stall_inc    = 1'b1;
        end else if (taken) begin
            // The three younger instructions are on the wrong path.
            pc_src       = mem_jump ? PC_SRC_JUMP : PC_SRC_BRANCH;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID; the ID/EX flush inserts the single bubble.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            stall_inc    = 1'b1;
        end

        // While reset is held the pipeline registers must see plain loads.
        if (!reset) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            pc_src       = PC_SRC_SEQ;
            dmem_req     = 1'b0;
            stall_inc    = 1'b0;
        end
    end

    // Saturating stall counter
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_inc && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end
    end

    // State follows the pipeline registers, which load on the falling edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed vector table, multi-cycle sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_write_register;
    logic       id_uses_rt, ex_mem_read;
    logic       mem_branch_eq, mem_branch_ne, mem_zero, mem_jump;
    logic       mem_mem_read, mem_mem_write, dmem_ready;

    logic        pcw1, ifw1, idw1, exw1, iff1, idf1, exf1, dreq1;
    logic [1:0]  src1;
    logic [15:0] cnt1;
    logic        pcw4, ifw4, idw4, exw4, iff4, idf4, exf4, dreq4;
    logic [1:0]  src4;
    logic [3:0]  cnt4;

    pipeline_hazard_ctrl #(.STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_register(ex_write_register),
        .mem_branch_eq(mem_branch_eq), .mem_branch_ne(mem_branch_ne),
        .mem_zero(mem_zero), .mem_jump(mem_jump),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .dmem_ready(dmem_ready),
        .pc_write(pcw1), .if_id_write(ifw1), .id_ex_write(idw1), .ex_mem_write(exw1),
        .if_id_flush(iff1), .id_ex_flush(idf1), .ex_mem_flush(exf1),
        .pc_src(src1), .dmem_req(dreq1), .stall_count(cnt1)
    );

    pipeline_hazard_ctrl #(.STALL_CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_register(ex_write_register),
        .mem_branch_eq(mem_branch_eq), .mem_branch_ne(mem_branch_ne),
        .mem_zero(mem_zero), .mem_jump(mem_jump),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .dmem_ready(dmem_ready),
        .pc_write(pcw4), .if_id_write(ifw4), .id_ex_write(idw4), .ex_mem_write(exw4),
        .if_id_flush(iff4), .id_ex_flush(idf4), .ex_mem_flush(exf4),
        .pc_src(src4), .dmem_req(dreq4), .stall_count(cnt4)
    );

    // Output vector: {pc_write, if_id_write, id_ex_write, ex_mem_write,
    //                 if_id_flush, id_ex_flush, ex_mem_flush, pc_src[1:0], dmem_req}
    wire [9:0] o1 = {pcw1, ifw1, idw1, exw1, iff1, idf1, exf1, src1, dreq1};
    wire [9:0] o4 = {pcw4, ifw4, idw4, exw4, iff4, idf4, exf4, src4, dreq4};

    localparam logic [9:0] E_NORM   = 10'b1111_000_00_0;
    localparam logic [9:0] E_NORM_M = 10'b1111_000_00_1;
    localparam logic [9:0] E_LU     = 10'b0011_010_00_0;
    localparam logic [9:0] E_BR     = 10'b1111_111_01_0;
    localparam logic [9:0] E_JMP    = 10'b1111_111_10_0;
    localparam logic [9:0] E_FRZ    = 10'b0000_000_00_1;

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt, ex_load;
        logic [4:0] ex_wr;
        logic       beq, bne, zero, jmp, mrd, mwr, rdy;
        logic [9:0] exp;
        logic       inc;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int mdl_cnt;     // unbounded stall count since last reset
    bit mdl_wait;    // a memory access is still outstanding

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_write_register = 5'd0;
        mem_branch_eq = 1'b0; mem_branch_ne = 1'b0; mem_zero = 1'b0; mem_jump = 1'b0;
        mem_mem_read = 1'b0; mem_mem_write = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
        ex_mem_read = v.ex_load; ex_write_register = v.ex_wr;
        mem_branch_eq = v.beq; mem_branch_ne = v.bne; mem_zero = v.zero; mem_jump = v.jmp;
        mem_mem_read = v.mrd; mem_mem_write = v.mwr; dmem_ready = v.rdy;
    endtask

    // Behavioural rules: what each pipeline register should do this cycle.
    function automatic logic [10:0] model();   // {stall_inc, outputs}
        bit busy, tk, hz, mop;
        mop  = mem_mem_read | mem_mem_write;
        busy = mop && !dmem_ready;
        tk   = (mem_branch_eq && mem_zero) || (mem_branch_ne && !mem_zero) || mem_jump;
        hz   = ex_mem_read && ex_write_register != 0 &&
               (ex_write_register == id_rs || (id_uses_rt && ex_write_register == id_rt));
        if (!reset)    return {1'b0, E_NORM};
        else if (busy) return {1'b1, E_FRZ};
        else if (tk)   return {1'b0, 7'b1111111, (mem_jump ? 2'b10 : 2'b01), mop};
        else if (hz)   return {1'b1, 9'b0011_010_00, mop};
        else           return {1'b0, 9'b1111_000_00, mop};
    endfunction

    // Inputs are already applied; check Mealy outputs mid-cycle, then the edge.
    task automatic cycle(input string nm);
        logic [10:0] m;
        #2;
        m = model();
        chk({nm, "/out"},  {22'd0, o1}, {22'd0, m[9:0]});
        chk({nm, "/out4"}, {22'd0, o4}, {22'd0, m[9:0]});
        @(negedge clk);
        if (!reset) begin
            mdl_cnt = 0; mdl_wait = 0;
        end else begin
            if (m[10]) mdl_cnt++;
            mdl_wait = (mem_mem_read | mem_mem_write) && !dmem_ready;
        end
        #1;
        chk({nm, "/cnt16"}, {16'd0, cnt1}, (mdl_cnt > 65535) ? 32'd65535 : mdl_cnt);
        chk({nm, "/cnt4"},  {28'd0, cnt4}, (mdl_cnt > 15) ? 32'd15 : mdl_cnt);
        chk({nm, "/state"}, {31'd0, dut.state_q == MEM_WAIT}, {31'd0, mdl_wait});
    endtask

    vec_t tbl[12];

    initial begin
        //        rs  rt  ur ld wr  beq bne z  j  mr mw rdy exp       inc
        tbl[0]  = '{5'd8, 5'd10, 1, 1, 5'd8, 0, 0, 0, 0, 0, 0, 1, E_LU,     1}; // lw $8; add $9,$8,$10
        tbl[1]  = '{5'd3, 5'd8,  1, 1, 5'd8, 0, 0, 0, 0, 0, 0, 1, E_LU,     1}; // rt match
        tbl[2]  = '{5'd3, 5'd8,  0, 1, 5'd8, 0, 0, 0, 0, 0, 0, 1, E_NORM,   0}; // rt not a source
        tbl[3]  = '{5'd0, 5'd0,  1, 1, 5'd0, 0, 0, 0, 0, 0, 0, 1, E_NORM,   0}; // $0 never hazards
        tbl[4]  = '{5'd1, 5'd2,  1, 1, 5'd7, 0, 0, 0, 0, 0, 0, 1, E_NORM,   0}; // no match
        tbl[5]  = '{5'd0, 5'd0,  0, 0, 5'd0, 1, 0, 1, 0, 0, 0, 1, E_BR,     0}; // beq taken
        tbl[6]  = '{5'd0, 5'd0,  0, 0, 5'd0, 1, 0, 0, 0, 0, 0, 1, E_NORM,   0}; // beq not taken
        tbl[7]  = '{5'd0, 5'd0,  0, 0, 5'd0, 0, 1, 0, 0, 0, 0, 1, E_BR,     0}; // bne taken
        tbl[8]  = '{5'd8, 5'd10, 1, 1, 5'd8, 0, 0, 0, 1, 0, 0, 1, E_JMP,    0}; // jump beats load-use
        tbl[9]  = '{5'd8, 5'd10, 1, 1, 5'd8, 1, 0, 1, 0, 1, 0, 0, E_FRZ,    1}; // freeze beats all
        tbl[10] = '{5'd0, 5'd0,  0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 1, E_NORM_M, 0}; // zero-wait sw
        tbl[11] = '{5'd8, 5'd10, 1, 0, 5'd8, 0, 0, 0, 0, 0, 0, 1, E_NORM,   0}; // not a load

        idle();
        reset = 1'b0;
        mdl_cnt = 0; mdl_wait = 0;
        #1;
        chk("rst/out",   {22'd0, o1}, {22'd0, E_NORM});
        chk("rst/cnt",   {16'd0, cnt1}, 32'd0);
        chk("rst/state", {31'd0, dut.state_q == MEM_WAIT}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b1;

        // Directed table: each row against hand-written expectations
        for (int i = 0; i < 12; i++) begin
            int c0;
            c0 = cnt1;
            apply_vec(tbl[i]);
            #2;
            chk($sformatf("tbl%0d/out", i), {22'd0, o1}, {22'd0, tbl[i].exp});
            @(negedge clk); #1;
            chk($sformatf("tbl%0d/inc", i), cnt1 - c0, {31'd0, tbl[i].inc});
        end
        mdl_cnt = cnt1 == 16'd3 ? 3 : -1000;   // table holds three stalling rows
        chk("tbl/total", {16'd0, cnt1}, 32'd3);
        mdl_wait = 0;

        // sw with three wait edges, then completion
        idle(); mem_mem_write = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("sw_wait%0d", i));
            chk($sformatf("sw_wait%0d/frz", i), {22'd0, o1}, {22'd0, E_FRZ});
            chk($sformatf("sw_wait%0d/st", i), {31'd0, dut.state_q == MEM_WAIT}, 32'd1);
        end
        chk("sw/cnt", {16'd0, cnt1}, 32'd6);
        dmem_ready = 1'b1;
        cycle("sw_done");
        chk("sw_done/st", {31'd0, dut.state_q == MEM_WAIT}, 32'd0);

        // Reset pulled low mid-wait
        idle(); mem_mem_read = 1'b1; dmem_ready = 1'b0;
        cycle("rw_enter");
        #2;
        reset = 1'b0;
        #1;
        mdl_cnt = 0; mdl_wait = 0;
        chk("rw/state", {31'd0, dut.state_q == MEM_WAIT}, 32'd0);
        chk("rw/cnt",   {16'd0, cnt1}, 32'd0);
        chk("rw/out",   {22'd0, o1}, {22'd0, E_NORM});
        @(negedge clk); #1;
        reset = 1'b1;
        idle();

        // Saturation of the 4-bit counter: 17 load-use stalls, then one more
        id_rs = 5'd5; ex_mem_read = 1'b1; ex_write_register = 5'd5;
        for (int i = 0; i < 17; i++) cycle("sat_fill");
        chk("sat/cnt4",  {28'd0, cnt4}, 32'd15);
        chk("sat/cnt16", {16'd0, cnt1}, 32'd17);
        cycle("sat_more");
        chk("sat/hold15", {28'd0, cnt4}, 32'd15);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom);
            ex_mem_read = 1'($urandom);
            ex_write_register = 5'($urandom_range(0, 3));
            mem_branch_eq = ($urandom_range(0, 3) == 0);
            mem_branch_ne = ($urandom_range(0, 3) == 0);
            mem_zero = 1'($urandom);
            mem_jump = ($urandom_range(0, 7) == 0);
            mem_mem_read = ($urandom_range(0, 3) == 0);
            mem_mem_write = ($urandom_range(0, 3) == 0);
            dmem_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 59) != 0);
            cycle("rand");
        end
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It generates per-stage write-enable and flush strobes for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, redirects on branches and jumps resolved in MEM, and freezes the pipeline while data memory is busy. It sits beside the datapath, reads the ID, EX and MEM stage fields, and drives the control inputs of the pipeline registers and the PC mux.

## Interface
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

- clk  in  1  clock; state updates on the falling edge, matching the pipeline registers.
- reset  in  1  reset, asynchronous, active-low.
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- ex_mem_read  in  1  the ID/EX stage holds a load.
- ex_write_register  in  5  destination register of the instruction in EX.
- mem_branch_eq, mem_branch_ne, mem_zero, mem_jump  in  1 each  EX/MEM control and flag outputs.
- mem_mem_read, mem_mem_write  in  1 each  the EX/MEM stage holds a memory access.
- dmem_ready  in  1  data memory has completed the current access.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load zero (bubble) at the next falling edge.
- pc_src  out  2  00 = PC+4, 01 = branch address, 10 = jump address.
- dmem_req  out  1  a data memory access is pending.
- stall_count  out  STALL_CNT_W  saturating count of frozen or stalled cycles.

## Operation
- FSM has two states: RUN and MEM_WAIT. Reset state is RUN.
- mem_op = mem_mem_read | mem_mem_write. dmem_req = mem_op in both states.
- taken = (mem_branch_eq & mem_zero) | (mem_branch_ne & ~mem_zero) | mem_jump.
- load_use = ex_mem_read & ex_write_register != 0 & (ex_write_register == id_rs | (id_uses_rt & ex_write_register == id_rt)).
- Priority, highest first: memory freeze, then redirect, then load-use, then normal.
- Memory freeze applies when mem_op & ~dmem_ready, in either state:
  - all four write enables are 0, all flushes are 0, pc_src = 00;
  - next state is MEM_WAIT.
- Redirect applies when taken and there is no freeze:
  - pc_write = 1; pc_src = 10 if mem_jump, else 01;
  - if_id_flush, id_ex_flush and ex_mem_flush are all 1; load_use is ignored.
- Load-use applies when there is no freeze and no redirect:
  - pc_write = 0, if_id_write = 0;
  - id_ex_flush = 1, ex_mem_write = 1.
- Normal: all write enables are 1, all flushes are 0, pc_src = 00.
- In MEM_WAIT, dmem_ready = 1 returns the state to RUN. That cycle is evaluated with the normal priorities (redirect or load-use may apply).
- stall_count increments by 1 on every falling edge where freeze or load-use applied, and saturates at all-ones.
- A flush has priority over its own write enable; flushed registers load the reset value.

## Timing
- All strobes are combinational (Mealy) from the state and inputs. They take effect at the next falling edge of clk.
- Load-use costs exactly 1 bubble. A taken branch or jump costs 3 flushed instructions.
- Freeze length equals the number of falling edges with dmem_ready = 0. A zero-wait access costs no cycles.
- While reset = 0, asynchronously:
  - state = RUN, stall_count = 0;
  - all write enables = 1, all flushes = 0, pc_src = 00, dmem_req = 0.
- Reset asserted mid-wait aborts MEM_WAIT immediately.

## Structure
- The shared pipeline package holds the pc_src encodings (PC_SRC_SEQ, PC_SRC_BRANCH, PC_SRC_JUMP) and the state encodings.
- One sub-module, hazard_detect_unit: purely combinational load_use and taken detection. The FSM and counter stay in the top module.

## Test plan
- lw $8 then add $9,$8,$10 in ID: exactly one cycle with pc_write = 0, id_ex_flush = 1; stall_count goes 0→1.
- beq with mem_zero = 1: pc_src = 01, the three flushes high for 1 cycle. The same case with mem_zero = 0 produces no redirect.
- mem_jump = 1 together with load_use = 1: pc_src = 10, flushes asserted, no load-use stall.
- sw with dmem_ready low for 3 edges: all enables 0 for 3 cycles, state MEM_WAIT, stall_count = 3, then RUN.
- Force stall_count to all-ones with STALL_CNT_W = 4 and stall again: the count stays at 15.
- reset pulled low during MEM_WAIT: state is RUN and stall_count = 0 immediately, and enables return to 1.
